// File: rtl/vco_freq_ctrl.sv
// Frequency-lock controller: counts divided VCO edges per reference window,
// compares them with the target and issues bounded up/down correction pulses.
module vco_freq_ctrl #(
  parameter int CNT_W        = 16,
  parameter int WINDOW       = 1024,
  parameter int TOL          = 2,
  parameter int LOCK_WINDOWS = 4,
  parameter int MAX_PULSES   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] target_i,
  input  logic             fb_clk_i,
  output logic             freq_incr_o,
  output logic             freq_decr_o,
  output logic             stable_cfg_o,
  output logic [CNT_W-1:0] meas_o,
  output logic             meas_valid_o,
  output logic [1:0]       dbg_state_o
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int PL_W  = $clog2(MAX_PULSES + 1);
  localparam int LK_W  = $clog2(LOCK_WINDOWS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    EVAL    = 2'd2,
    ADJUST  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             start_win;
  logic             fb_s1, fb_s2, fb_s3;
  logic             edge_det;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] meas_q;
  logic [LK_W-1:0]  lock_cnt;
  logic [LK_W-1:0]  lock_inc;
  logic [PL_W-1:0]  pulses_left;
  logic [PL_W-1:0]  pulses_calc;
  logic             phase_low;
  logic             dir_incr;
  logic             stable_q;
  logic             win_last;
  logic             in_band;
  logic signed [CNT_W:0] err;
  logic [CNT_W:0]   abs_err;

  // fb_clk_i is asynchronous: two sync flops, the third flop is the edge detector
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fb_s1 <= 1'b0;
      fb_s2 <= 1'b0;
      fb_s3 <= 1'b0;
    end else begin
      fb_s1 <= fb_clk_i;
      fb_s2 <= fb_s1;
      fb_s3 <= fb_s2;
    end
  end

  assign edge_det = fb_s2 & ~fb_s3;
  assign win_last = (win_cnt == WIN_W'(WINDOW - 1));

  assign err     = $signed({1'b0, edge_cnt}) - $signed({1'b0, tgt});
  assign abs_err = err[CNT_W] ? $unsigned(-err) : $unsigned(err);
  assign in_band = (abs_err <= (CNT_W + 1)'(TOL));
  assign pulses_calc = (abs_err > (CNT_W + 1)'(MAX_PULSES)) ? PL_W'(MAX_PULSES)
                                                            : PL_W'(abs_err);
  assign lock_inc = (lock_cnt == LK_W'(LOCK_WINDOWS)) ? lock_cnt : lock_cnt + LK_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_win = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d   = MEASURE;
          start_win = 1'b1;
        end
      end
      MEASURE: begin
        if (win_last) state_d = EVAL;
      end
      EVAL: begin
        if (in_band) begin
          state_d   = MEASURE;
          start_win = 1'b1;
        end else begin
          state_d = ADJUST;
        end
      end
      ADJUST: begin
        if (phase_low && pulses_left == '0) begin
          state_d   = MEASURE;
          start_win = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en_i) begin
      state_d   = IDLE;
      start_win = 1'b0;
    end
  end

  // Window/edge counters and target latch; edges outside MEASURE are dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
      tgt      <= '0;
      meas_q   <= '0;
    end else begin
      if (start_win) begin
        tgt      <= target_i;
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else if (state_q == MEASURE) begin
        win_cnt <= win_cnt + WIN_W'(1);
        if (edge_det && !(&edge_cnt)) edge_cnt <= edge_cnt + CNT_W'(1);
      end
      if (state_q == EVAL) meas_q <= edge_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      lock_cnt    <= '0;
      stable_q    <= 1'b0;
      pulses_left <= '0;
      phase_low   <= 1'b0;
      dir_incr    <= 1'b0;
    end else begin
      case (state_q)
        EVAL: begin
          if (in_band) begin
            lock_cnt <= lock_inc;
            if (lock_inc == LK_W'(LOCK_WINDOWS)) stable_q <= 1'b1;
          end else begin
            lock_cnt    <= '0;
            stable_q    <= 1'b0;
            pulses_left <= pulses_calc;
            phase_low   <= 1'b0;
            dir_incr    <= err[CNT_W];
          end
        end
        ADJUST: begin
          if (!phase_low) begin
            pulses_left <= pulses_left - PL_W'(1);
            phase_low   <= 1'b1;
          end else begin
            phase_low <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // During EVAL the fresh count is shown directly so it lines up with the strobe
  assign meas_o       = (state_q == EVAL) ? edge_cnt : meas_q;
  assign meas_valid_o = (state_q == EVAL);
  assign freq_incr_o  = (state_q == ADJUST) && !phase_low && dir_incr;
  assign freq_decr_o  = (state_q == ADJUST) && !phase_low && !dir_incr;
  assign stable_cfg_o = stable_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_vco_freq_ctrl.sv
// Directed bench for vco_freq_ctrl: in-band lock, slow/fast correction,
// clamping, lock loss, enable drop and reset, against hand-computed values.
`timescale 1ns/1ps
module tb_vco_freq_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0, S_MEAS = 2'd1, S_ADJ = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] target = '0;
  logic        fb_clk = 1'b0;
  logic        incr, decr, stable, valid;
  logic [15:0] meas;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  int both_cnt = 0;
  logic [15:0] exp_q[$];
  logic [31:0] inc_pat, dec_pat, stb_pat;
  logic [1:0]  st_log [0:31];

  vco_freq_ctrl #(
    .CNT_W(16), .WINDOW(64), .TOL(1), .LOCK_WINDOWS(2), .MAX_PULSES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .target_i(target), .fb_clk_i(fb_clk),
    .freq_incr_o(incr), .freq_decr_o(decr), .stable_cfg_o(stable),
    .meas_o(meas), .meas_valid_o(valid), .dbg_state_o(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Feedback clock stepped on clk negedges; period in clk cycles. A request of 4
  // re-phases so that any 64-cycle count window after the switch sees exactly 16 rises.
  int fb_per = 8;
  int fb_ph = 7;
  int fb_req = 0;
  bit fb_run = 1'b0;

  always @(negedge clk) begin
    if (!fb_run) begin
      fb_clk = 1'b0;
      fb_ph  = fb_per - 1;
    end else begin
      if (fb_req == 4) begin
        fb_per = 4;
        case (fb_ph)
          0:       fb_ph = 1;
          1:       fb_ph = 2;
          2, 3:    fb_ph = 3;
          default: fb_ph = 0;
        endcase
      end else if (fb_req != 0) begin
        fb_per = fb_req;
        fb_ph  = 0;
      end else begin
        fb_ph = (fb_ph + 1) % fb_per;
      end
      fb_req = 0;
      fb_clk = (fb_ph < fb_per / 2);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wait_eval(input int exp_lat, input string tag);
    int n;
    logic [15:0] exp_m;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (incr || decr) pulse_cnt++;
    end while (!valid && n < 200);
    check_eq({tag, "_lat"}, n, exp_lat);
    exp_m = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check_eq({tag, "_meas"}, {16'd0, meas}, {16'd0, exp_m});
  endtask

  task automatic capture(input int n);
    inc_pat = '0;
    dec_pat = '0;
    stb_pat = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      inc_pat[k] = incr;
      dec_pat[k] = decr;
      stb_pat[k] = stable;
      st_log[k]  = dbg_state;
      if (incr && decr) both_cnt++;
    end
  endtask

  task automatic go_idle(input string tag);
    en = 1'b0;
    @(negedge clk);
    check_eq({tag, "_st"}, {30'd0, dbg_state}, {30'd0, S_IDLE});
    check_eq({tag, "_stb"}, {31'd0, stable}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_incr"}, {31'd0, incr}, 32'd0);
    check_eq({tag, "_decr"}, {31'd0, decr}, 32'd0);
    check_eq({tag, "_stb"}, {31'd0, stable}, 32'd0);
    check_eq({tag, "_meas"}, {16'd0, meas}, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check_eq({tag, "_st"}, {30'd0, dbg_state}, {30'd0, S_IDLE});
  endtask

  initial begin
    fb_run = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("rst0");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // in-band lock at 8 edges per window
    target = 16'd8;
    exp_q.push_back(16'd8);
    exp_q.push_back(16'd8);
    exp_q.push_back(16'd8);
    pulse_cnt = 0;
    en = 1'b1;
    wait_eval(65, "ib1");
    wait_eval(65, "ib2");
    check_eq("ib2_stb_pre", {31'd0, stable}, 32'd0);
    @(negedge clk);
    check_eq("ib_stb_rise", {31'd0, stable}, 32'd1);
    wait_eval(64, "ib3");
    check_eq("ib3_stb", {31'd0, stable}, 32'd1);
    check_eq("ib_no_pulse", pulse_cnt, 32'd0);

    // lock loss: feedback doubles to 16 edges per window
    #1 fb_req = 4;
    exp_q.push_back(16'd16);
    wait_eval(65, "ll");
    check_eq("ll_stb_at_eval", {31'd0, stable}, 32'd1);
    capture(17);
    check_eq("ll_stb", stb_pat, 32'd0);
    check_eq("ll_dec", dec_pat, 32'h0000_5555);
    check_eq("ll_inc", inc_pat, 32'd0);
    check_eq("ll_st_end", {30'd0, st_log[16]}, {30'd0, S_MEAS});
    go_idle("ll_off");
    #1 fb_req = 8;
    repeat (20) @(negedge clk);

    // too slow: target 12, four incr pulses
    target = 16'd12;
    exp_q.push_back(16'd8);
    exp_q.push_back(16'd8);
    en = 1'b1;
    wait_eval(65, "slow");
    capture(17);
    check_eq("slow_inc", inc_pat, 32'h0000_0055);
    check_eq("slow_dec", dec_pat, 32'd0);
    check_eq("slow_stb", stb_pat, 32'd0);
    check_eq("slow_st_adj", {30'd0, st_log[7]}, {30'd0, S_ADJ});
    check_eq("slow_st_meas", {30'd0, st_log[8]}, {30'd0, S_MEAS});
    wait_eval(56, "slow2");
    go_idle("slow_off");

    // too fast: target 0, err +8
    target = 16'd0;
    exp_q.push_back(16'd8);
    en = 1'b1;
    wait_eval(65, "fast");
    capture(17);
    check_eq("fast_dec", dec_pat, 32'h0000_5555);
    check_eq("fast_inc", inc_pat, 32'd0);
    check_eq("fast_st_adj", {30'd0, st_log[15]}, {30'd0, S_ADJ});
    check_eq("fast_st_meas", {30'd0, st_log[16]}, {30'd0, S_MEAS});
    go_idle("fast_off");

    // clamp: target 30, err -22 limited to 8 pulses
    target = 16'd30;
    exp_q.push_back(16'd8);
    en = 1'b1;
    wait_eval(65, "clamp");
    capture(17);
    check_eq("clamp_inc", inc_pat, 32'h0000_5555);
    check_eq("clamp_dec", dec_pat, 32'd0);
    go_idle("clamp_off");

    // enable dropped after 2 of 6 decr pulses
    target = 16'd2;
    exp_q.push_back(16'd8);
    en = 1'b1;
    wait_eval(65, "drop");
    capture(3);
    check_eq("drop_dec_pre", dec_pat, 32'h0000_0005);
    en = 1'b0;
    capture(10);
    check_eq("drop_dec_post", dec_pat, 32'd0);
    check_eq("drop_inc_post", inc_pat, 32'd0);
    check_eq("drop_stb", stb_pat, 32'd0);
    check_eq("drop_st0", {30'd0, st_log[0]}, {30'd0, S_IDLE});
    check_eq("drop_st9", {30'd0, st_log[9]}, {30'd0, S_IDLE});
    check_eq("drop_meas_hold", {16'd0, meas}, 32'd8);
    target = 16'd8;
    exp_q.push_back(16'd8);
    en = 1'b1;
    wait_eval(65, "reen");

    // one-cycle reset mid-MEASURE, feedback held low afterwards
    repeat (20) @(negedge clk);
    rst = 1'b1;
    fb_run = 1'b0;
    @(negedge clk);
    check_all_zero("rst1");
    rst = 1'b0;
    exp_q.push_back(16'd0);
    wait_eval(65, "rst_eval");
    capture(17);
    check_eq("rst_inc", inc_pat, 32'h0000_5555);
    check_eq("rst_dec", dec_pat, 32'd0);

    check_eq("excl", both_cnt, 32'd0);
    check_eq("exp_q_empty", exp_q.size(), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
